// File: rtl/key_event_scheduler_if.sv
// Event handshake between the key event scheduler and its consumer.
// The scheduler drives the head event; the consumer answers with ev_ready.
interface key_event_scheduler_if #(
    parameter int unsigned N_KEYS = 4
);
    localparam int unsigned KW = $clog2(N_KEYS);

    logic          ev_valid;
    logic [KW-1:0] ev_key;
    logic          ev_long;
    logic          ev_ready;

    modport master (
        output ev_valid,
        output ev_key,
        output ev_long,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_key,
        input  ev_long,
        output ev_ready
    );
endinterface

// File: rtl/key_event_scheduler.sv
// Collects short/long press pulses from per-button classifiers into per-key
// pending bits, arbitrates round-robin between keys and queues one event per
// cycle into a small FIFO. Dropped pulses raise a sticky overflow flag.
module key_event_scheduler #(
    parameter int unsigned N_KEYS = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [N_KEYS-1:0]            short,
    input  logic [N_KEYS-1:0]            long,
    key_event_scheduler_if.master        ev,
    output logic [N_KEYS-1:0]            pending,
    output logic                         overflow,
    input  logic                         clr_ovf
);
    localparam int unsigned KW = $clog2(N_KEYS);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [KW-1:0] LAST_KEY = KW'(N_KEYS - 1);

    logic [N_KEYS-1:0] s_q, s_d, l_q, l_d;
    logic [N_KEYS-1:0] clr_s, clr_l, eligible;
    logic [KW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [KW:0]       mem_q [DEPTH];
    logic [KW:0]       head;

    logic          ev_valid, pop, push_ok, push, push_long, drop;
    logic          hi_found, lo_found, gnt_valid;
    logic [KW-1:0] hi_idx, lo_idx, gnt_idx;

    assign eligible = s_q | l_q;
    assign ev_valid = (count_q != '0);
    assign pop      = ev_valid && ev.ev_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign push_ok  = (count_q != DEPTH_C) || pop;

    // Round-robin search: lowest eligible key at or above ptr, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = int'(N_KEYS) - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                lo_found = 1'b1;
                lo_idx   = KW'(k);
                if (KW'(k) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = KW'(k);
                end
            end
        end
        gnt_valid = hi_found | lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Grant, pending-bit update and drop detection; long wins within a key.
    always_comb begin
        clr_s     = '0;
        clr_l     = '0;
        push      = gnt_valid && push_ok;
        push_long = l_q[gnt_idx];
        ptr_d     = ptr_q;
        if (push) begin
            if (push_long) begin
                clr_l[gnt_idx] = 1'b1;
            end else begin
                clr_s[gnt_idx] = 1'b1;
            end
            ptr_d = (gnt_idx == LAST_KEY) ? '0 : gnt_idx + KW'(1);
        end
        // A pulse landing on a bit cleared this cycle simply re-arms it.
        s_d   = (s_q & ~clr_s) | short;
        l_d   = (l_q & ~clr_l) | long;
        drop  = |((short & s_q & ~clr_s) | (long & l_q & ~clr_l));
        ovf_d = (ovf_q & ~clr_ovf) | drop;
    end

    // FIFO occupancy bookkeeping.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards pending and queued events at once.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s_q     <= '0;
            l_q     <= '0;
            ptr_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            l_q     <= l_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    // Event storage; entries are only meaningful while counted as occupied.
    always_ff @(posedge Clock) begin
        if (push) mem_q[wptr_q] <= {gnt_idx, push_long};
    end

    assign head        = mem_q[rptr_q];
    assign ev.ev_valid = ev_valid;
    assign ev.ev_key   = ev_valid ? head[KW:1] : '0;
    assign ev.ev_long  = ev_valid ? head[0] : 1'b0;
    assign pending     = eligible;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with N_KEYS=4, DEPTH=4.
// Inputs change 1ns after a rising edge; outputs are checked at that point.
module tb_key_event_scheduler;
    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] short, long;
    logic [3:0] pending;
    logic       overflow, clr_ovf;
    int         checks = 0;
    int         failures = 0;

    key_event_scheduler_if #(.N_KEYS(4)) ev_if ();

    key_event_scheduler #(.N_KEYS(4), .DEPTH(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .short    (short),
        .long     (long),
        .ev       (ev_if),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic v, input logic [1:0] k, input logic l);
        chk({tag, ".valid"}, 32'(ev_if.ev_valid), 32'(v));
        chk({tag, ".key"}, 32'(ev_if.ev_key), 32'(k));
        chk({tag, ".long"}, 32'(ev_if.ev_long), 32'(l));
    endtask

    // One-cycle pulse; returns just after the edge that captured it.
    task automatic pulse(input logic [3:0] s, input logic [3:0] l);
        short = s;
        long  = l;
        tick();
        short = '0;
        long  = '0;
    endtask

    initial begin
        Reset = 1'b1;
        short = '0;
        long = '0;
        clr_ovf = 1'b0;
        ev_if.ev_ready = 1'b0;
        #2 Reset = 1'b0;
        #1;
        head("rst", 1'b0, 2'd0, 1'b0);
        chk("rst.pending", 32'(pending), 32'h0);
        chk("rst.overflow", 32'(overflow), 32'h0);
        tick();
        tick();
        Reset = 1'b1;

        // All four keys at once drain in index order 0..3.
        ev_if.ev_ready = 1'b1;
        pulse(4'hF, 4'h0);
        chk("all.pending0", 32'(pending), 32'hF);
        chk("all.valid0", 32'(ev_if.ev_valid), 32'h0);
        tick(); head("all.e0", 1'b1, 2'd0, 1'b0); chk("all.pending1", 32'(pending), 32'hE);
        tick(); head("all.e1", 1'b1, 2'd1, 1'b0); chk("all.pending2", 32'(pending), 32'hC);
        tick(); head("all.e2", 1'b1, 2'd2, 1'b0); chk("all.pending3", 32'(pending), 32'h8);
        tick(); head("all.e3", 1'b1, 2'd3, 1'b0); chk("all.pending4", 32'(pending), 32'h0);
        tick(); chk("all.empty", 32'(ev_if.ev_valid), 32'h0);

        // Pointer back at 0: keys 0 and 3 come out as 0 then 3.
        pulse(4'h9, 4'h0);
        tick(); head("wrap.e0", 1'b1, 2'd0, 1'b0);
        tick(); head("wrap.e1", 1'b1, 2'd3, 1'b0);
        tick(); chk("wrap.empty", 32'(ev_if.ev_valid), 32'h0);

        // Single short press on key 2: valid two cycles after the pulse, for one cycle.
        pulse(4'h4, 4'h0);
        chk("lat.t1", 32'(ev_if.ev_valid), 32'h0);
        tick(); head("lat.t2", 1'b1, 2'd2, 1'b0);
        tick(); chk("lat.t3", 32'(ev_if.ev_valid), 32'h0);

        // Long and short together on key 1: long first.
        pulse(4'h2, 4'h2);
        tick(); head("ls.e0", 1'b1, 2'd1, 1'b1); chk("ls.pending", 32'(pending), 32'h2);
        tick(); head("ls.e1", 1'b1, 2'd1, 1'b0); chk("ls.pending1", 32'(pending), 32'h0);
        tick(); chk("ls.empty", 32'(ev_if.ev_valid), 32'h0);

        // New pulse on the very cycle its bit is being cleared is kept.
        pulse(4'h1, 4'h0);
        pulse(4'h1, 4'h0);
        head("rearm.e0", 1'b1, 2'd0, 1'b0);
        chk("rearm.pending", 32'(pending), 32'h1);
        chk("rearm.overflow", 32'(overflow), 32'h0);
        tick(); head("rearm.e1", 1'b1, 2'd0, 1'b0); chk("rearm.pending1", 32'(pending), 32'h0);
        tick(); chk("rearm.empty", 32'(ev_if.ev_valid), 32'h0);

        // Back-pressure: five presses, four queued, key 0 left pending.
        ev_if.ev_ready = 1'b0;
        pulse(4'h1, 4'h0);
        pulse(4'h2, 4'h0);
        pulse(4'h4, 4'h0);
        pulse(4'h8, 4'h0);
        pulse(4'h1, 4'h0);
        head("bp.full", 1'b1, 2'd0, 1'b0);
        chk("bp.pending", 32'(pending), 32'h1);
        tick();
        head("bp.hold", 1'b1, 2'd0, 1'b0);
        chk("bp.pending_hold", 32'(pending), 32'h1);
        chk("bp.overflow", 32'(overflow), 32'h0);
        ev_if.ev_ready = 1'b1;
        tick(); head("bp.d1", 1'b1, 2'd1, 1'b0); chk("bp.pending_d1", 32'(pending), 32'h0);
        tick(); head("bp.d2", 1'b1, 2'd2, 1'b0);
        tick(); head("bp.d3", 1'b1, 2'd3, 1'b0);
        tick(); head("bp.d4", 1'b1, 2'd0, 1'b0);
        tick(); chk("bp.empty", 32'(ev_if.ev_valid), 32'h0);

        // Fill the FIFO (pointer at 1 -> head is key 1), then overflow key 3.
        ev_if.ev_ready = 1'b0;
        pulse(4'hF, 4'h0);
        repeat (4) tick();
        head("ovf.head", 1'b1, 2'd1, 1'b0);
        chk("ovf.pending0", 32'(pending), 32'h0);
        pulse(4'h8, 4'h0);
        chk("ovf.pending1", 32'(pending), 32'h8);
        chk("ovf.flag0", 32'(overflow), 32'h0);
        pulse(4'h8, 4'h0);
        chk("ovf.flag1", 32'(overflow), 32'h1);
        chk("ovf.pending2", 32'(pending), 32'h8);
        clr_ovf = 1'b1;
        pulse(4'h8, 4'h0);
        clr_ovf = 1'b0;
        chk("ovf.setwins", 32'(overflow), 32'h1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf.cleared", 32'(overflow), 32'h0);
        head("ovf.stable", 1'b1, 2'd1, 1'b0);
        pulse(4'h0, 4'h4);
        chk("ovf.pending3", 32'(pending), 32'hC);

        // Asynchronous reset with events queued and pending.
        Reset = 1'b0;
        #1;
        head("arst", 1'b0, 2'd0, 1'b0);
        chk("arst.pending", 32'(pending), 32'h0);
        chk("arst.overflow", 32'(overflow), 32'h0);
        tick();
        ev_if.ev_ready = 1'b1;
        Reset = 1'b1;
        pulse(4'h2, 4'h0);
        chk("post.pending", 32'(pending), 32'h2);
        chk("post.valid0", 32'(ev_if.ev_valid), 32'h0);
        tick(); head("post.e0", 1'b1, 2'd1, 1'b0);
        tick(); chk("post.empty0", 32'(ev_if.ev_valid), 32'h0);
        chk("post.pending1", 32'(pending), 32'h0);
        tick(); chk("post.empty1", 32'(ev_if.ev_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_event_scheduler.md
KEY_EVENT_SCHEDULER -- requirements
Module: key_event_scheduler

Interface
REQ-001 Parameter N_KEYS, default 4: number of classified buttons served; legal range 2..8.
REQ-002 Parameter DEPTH, default 4: event FIFO depth; power of two, legal range 2..16.
REQ-003 Clock  in  1  system clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 short  in  N_KEYS  per-key one-cycle short-press pulses from the per-button classifiers.
REQ-006 long  in  N_KEYS  per-key one-cycle long-press pulses from the per-button classifiers.
REQ-007 ev_valid  out  1  FIFO head holds a valid event.
REQ-008 ev_key  out  clog2(N_KEYS)  key index of the head event.
REQ-009 ev_long  out  1  head event type: 1 = long, 0 = short.
REQ-010 ev_ready  in  1  consumer accepts the head event.
REQ-011 pending  out  N_KEYS  per-key OR of the short-pending and long-pending bits.
REQ-012 overflow  out  1  sticky dropped-event flag.
REQ-013 clr_ovf  in  1  synchronous clear of overflow.

Function
REQ-014 Each key SHALL have two pending bits, S[k] and L[k], set on the rising edge after short[k] or long[k], respectively, is high.
REQ-015 A key is eligible when S[k] or L[k] is set; arbitration is combinational on registered pending bits.
REQ-016 Round-robin: grant the first eligible key at index >= ptr, wrapping modulo N_KEYS; ptr resets to 0.
REQ-017 The grant SHALL occur only when push is allowed (REQ-021); on grant, ptr <= (granted index + 1) mod N_KEYS.
REQ-018 Within a granted key, L[k] has priority: push {k, long=1} and clear L[k]; otherwise push {k, long=0} and clear S[k]; one event per cycle maximum.
REQ-019 Same-cycle clear and new pulse of the same type on the same key: the bit SHALL remain set (new event retained, none lost).
REQ-020 A pulse arriving while its pending bit is already set and not being cleared that cycle SHALL be dropped, and overflow <= 1.
REQ-021 FIFO push allowed when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-022 Pop occurs when ev_valid && ev_ready; ev_valid = (count != 0); ev_key and ev_long SHALL be stable while ev_valid && !ev_ready.
REQ-023 Order: events leave in the order pushed; count changes +1 (push only), -1 (pop only), 0 (both or neither).
REQ-024 Latency: a pulse in cycle t with an empty FIFO and no contention gives ev_valid = 1 in cycle t+2.
REQ-025 overflow: set per REQ-020; cleared by clr_ovf; if set and clear coincide, set wins.
REQ-026 Pointer wrap: read and write pointers SHALL be clog2(DEPTH) bits and wrap naturally; full and empty are distinguished by count, not by pointer equality alone.
REQ-027 Pending bits and FIFO contents SHALL be unaffected by the state of ev_ready, except through the push-allowed rule in REQ-021.

Reset
REQ-028 While Reset = 0: S, L, ptr, the FIFO pointers, count and overflow SHALL all be 0; ev_valid = 0, ev_key = 0, ev_long = 0, pending = 0.
REQ-029 Reset asserted mid-operation SHALL discard all pending and queued events immediately, without waiting for a clock edge.
REQ-030 Pulses present in the first cycle after reset deassertion SHALL be captured normally.

Verification
REQ-031 short[2] pulsed one cycle, ev_ready = 1 -> ev_valid high exactly 2 cycles later with ev_key = 2, ev_long = 0, for exactly one cycle.
REQ-032 short = 4'b1111 pulsed together, ev_ready = 1 -> events emitted with keys 0, 1, 2, 3 on consecutive cycles; ptr returns to 0.
REQ-033 long[1] and short[1] pulsed together -> events {1, long} then {1, short}.
REQ-034 ev_ready = 0 with 5 distinct short pulses on keys 0..3 then key 0 again, DEPTH = 4 -> count saturates at 4; key 0 stays pending; overflow = 0; raising ev_ready drains all 5 events in order.
REQ-035 short[3] pulsed twice while the FIFO is full and ev_ready = 0 -> second pulse dropped, overflow = 1; clr_ovf -> overflow = 0 on the next cycle.
REQ-036 Reset asserted with 3 queued events and 2 pending -> ev_valid = 0 and pending = 0 immediately; no stale events after release.
